// File: rtl/shift_unit_seq.sv
// Multicycle shifter: latches an operand, shift amount and shift kind on start,
// then shifts the operand one bit per clock. done pulses for one cycle when the
// result is final.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high reset
//   start    - shift request, sampled only in IDLE
//   op       - shift kind: 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   shamt    - shift amount
//   data_in  - operand
//   busy     - high while shifting
//   done     - one-cycle pulse, data_out is final
//   data_out - working/result register
module shift_unit_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t             state, state_nxt;
    logic [SHAMT_W-1:0] count, count_nxt;
    logic [1:0]         op_r, op_nxt;
    logic [WIDTH-1:0]   data_nxt;
    logic               busy_nxt, done_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            op_r     <= OP_SLL;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            op_r     <= op_nxt;
            data_out <= data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        op_nxt    = op_r;
        data_nxt  = data_out;

        unique case (state)
            IDLE: begin
                if (start) begin
                    data_nxt  = data_in;
                    count_nxt = shamt;
                    op_nxt    = op;
                    // a zero shift skips SHIFT so count never wraps
                    state_nxt = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                unique case (op_r)
                    OP_SLL:  data_nxt = {data_out[WIDTH-2:0], 1'b0};
                    OP_SRL:  data_nxt = {1'b0, data_out[WIDTH-1:1]};
                    OP_SRA:  data_nxt = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
                    OP_ROR:  data_nxt = {data_out[0], data_out[WIDTH-1:1]};
                    default: data_nxt = data_out;
                endcase
                count_nxt = count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // registered decode of the next state keeps busy/done aligned with state
        busy_nxt = (state_nxt == SHIFT);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Testbench for shift_unit_seq: directed and random shifts, checked by a
// scoreboard against an arithmetic reference model.
module tb_shift_unit_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    typedef struct {
        logic [31:0] data;
        int          k;
        int          n;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          busy_cnt = 0;
    logic [31:0] last_res = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int n);
        logic [31:0] r;
        case (o)
            2'b00:   r = d << n;
            2'b01:   r = d >> n;
            2'b10:   r = 32'($signed(d) >>> n);
            default: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
        return r;
    endfunction

    // Monitor: compares every done pulse against the oldest expected result
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result", data_out, e.data);
                    check("done_latency", 32'(cyc), 32'(e.k + e.n));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.n));
                    last_res = e.data;
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive a start for one cycle; call at posedge+#1 with the DUT in IDLE
    task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
        exp_t e;
        e.data  = ref_shift(o, d, int'(s));
        e.k     = cyc + 1;
        e.n     = int'(s);
        q.push_back(e);
        op      = o;
        shamt   = s;
        data_in = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = $urandom;
        shamt   = $urandom;
        data_in = $urandom;
    endtask

    // Wait until the scoreboard drains, then step into the IDLE cycle
    task automatic wait_done();
        int guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (q.size() != 0) begin
            check("done_timeout", 32'(q.size()), 32'h0);
            q.delete();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
        issue(o, s, d);
        wait_done();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        shamt   = 5'd0;
        data_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_data_out", data_out, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(posedge clk);
        #1;

        // Directed cases
        run(2'b00, 5'd16, 32'h0000_0001);
        check("sll16_value", last_res, 32'h0001_0000);
        run(2'b10, 5'd4, 32'h8000_0000);
        check("sra4_value", last_res, 32'hF800_0000);
        run(2'b01, 5'd4, 32'h8000_0000);
        check("srl4_value", last_res, 32'h0800_0000);
        run(2'b11, 5'd1, 32'h0000_0001);
        check("ror1_value", last_res, 32'h8000_0000);
        run(2'b11, 5'd31, 32'h8000_0000);
        check("ror31_value", last_res, 32'h0000_0001);
        run(2'b00, 5'd0, 32'hDEAD_BEEF);
        check("shamt0_value", last_res, 32'hDEAD_BEEF);
        @(negedge clk);
        check("hold_after_done", data_out, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // start pulsed mid-shift must be ignored
        issue(2'b00, 5'd8, 32'h1234_5678);
        repeat (3) @(posedge clk);
        #1;
        op      = 2'b01;
        shamt   = 5'd3;
        data_in = 32'hFFFF_FFFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        wait_done();
        check("ignored_start_value", last_res, 32'h3456_7800);

        // reset mid-shift discards the operation
        issue(2'b10, 5'd20, 32'h8765_4321);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_data_out", data_out, 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_done", 32'(done), 32'h0);
        repeat (25) @(posedge clk);
        #1;
        run(2'b10, 5'd3, 32'h8000_00F0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [4:0]  rs;
            logic [31:0] rd;
            ro = 2'($urandom_range(0, 3));
            rs = (i % 8 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            rd = $urandom;
            run(ro, rs, rd);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
